uart_rx_oversampler: RTL and testbench
======================================

// Module: uart_rx_oversampler
// PURPOSE
//   Receive-side bit engine, directly downstream of the UART transmitter: consumes the
//   serial line, oversamples it with the 16x baud tick from baud_generator, majority-votes
//   each bit, and delivers one deserialised character per frame.
//   Feeds the RX FIFO / register layer via a one-cycle valid strobe with error flags.
// PARAMETERS
//   SAMPLING_RATE  16  ticks per bit period; even and >= 8.
// PORTS
//   clk             in   1  system clock; all logic on rising edge
//   reset           in   1  synchronous reset, active-high
//   rx_en_i         in   1  receiver enable; 0 forces IDLE
//   tick_i          in   1  oversample tick, 1-cycle pulse, SAMPLING_RATE per bit
//   rx_i            in   1  serial line, idle high, asynchronous
//   data_bit_num_i  in   2  00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i     in   1  1 = parity bit present after data
//   parity_type_i   in   1  0 = even, 1 = odd
//   stop_bit_num_i  in   1  0 = 1 stop bit, 1 = 2 stop bits
//   data_o          out  8  received char, LSB = first bit, unused MSBs = 0
//   data_valid_o    out  1  1-cycle strobe, data_o/error flags valid
//   parity_err_o    out  1  parity mismatch for this char, valid with data_valid_o
//   stop_bit_err_o  out  1  any stop sample = 0, valid with data_valid_o
//   busy_o          out  1  1 in any state except IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, tick counter=0, bit index=0, shift reg=0, sync flops=1,
//     data_o=0, data_valid_o=0, parity_err_o=0, stop_bit_err_o=0, busy_o=0.
//   - rx_i passes through a 2-flop synchroniser (reset to 1); all decisions use rx_s.
//   - Settings sampled into internal regs on the IDLE->START transition; changes mid-frame
//     have no effect until the next frame.
//   - Tick counter cnt counts tick_i, 0..SAMPLING_RATE-1, wraps to 0 and advances bit.
//   - Bit value = majority of rx_s at cnt = M-1, M, M+1 (M = SAMPLING_RATE/2), decided
//     on the tick with cnt = M+1. All action happens only on cycles with tick_i=1.
//   - FSM:
//     IDLE   : tick_i & rx_en_i & rx_s==0 -> START, cnt=0.
//     START  : at decision point, voted 1 -> IDLE (false start, no output);
//              voted 0 -> continue; at cnt wrap -> DATA, bit index=0.
//     DATA   : shift voted bit in LSB-first; after bit N-1 (N=5..8) wrap -> PARITY if
//              parity_en else STOP.
//     PARITY : voted bit vs XOR(data)^parity_type; mismatch latches parity error.
//     STOP   : decision point of stop1 (and stop2 if 2 stop bits, full bit between);
//              voted 0 latches stop error. At decision point of the LAST stop bit:
//              present outputs, go IDLE immediately (no wait for end of stop bit),
//              so a start edge right after the stop mid-point is caught.
//   - Output timing: data_o, parity_err_o, stop_bit_err_o update and data_valid_o=1 on
//     the clock edge after the tick of the last stop decision; data_valid_o high exactly
//     one cycle; data_o and error flags hold until next valid strobe.
//   - Stop error does not suppress data; char always delivered with flags.
//   - rx_en_i=0 in any state: next edge -> IDLE, cnt=0, no data_valid_o, outputs hold.
//   - reset mid-frame: reset values next edge; partial char discarded.
//   - tick_i absent: FSM frozen, no timeout.
//   - Break (line held 0): frame completes with data 0 and stop_bit_err_o=1; receiver then
//     waits in IDLE, re-entering START only after rx_s seen 1 then 0.
// TESTING
//   1. 8N1, SAMPLING_RATE=16, send 0xA5 -> one data_valid_o pulse, data_o=0xA5, both errs 0.
//   2. 7 bits, even parity, send 0x55 with parity bit forced 1 -> data_o=0x55, parity_err_o=1.
//   3. 8 bits, 2 stop bits, 0x3C with stop2 driven 0 -> data_o=0x3C, stop_bit_err_o=1.
//   4. rx_i low for 4 ticks then high -> START then IDLE, no data_valid_o, busy_o back to 0.
//   5. 1-tick glitch at cnt=M during each data bit of 0xF0 -> majority vote gives data_o=0xF0.
//   6. rx_en_i dropped during bit 3, then reset pulse mid-frame -> no valid, outputs at reset,
//      then back-to-back 0x11,0x22 frames -> two pulses in order.

Source files
------------

// File: rtl/uart_rx_oversampler_if.sv
// uart_rx_oversampler_if: serial line, frame settings and received-character strobe bundle
interface uart_rx_oversampler_if;
    logic       rx_en_i;
    logic       tick_i;
    logic       rx_i;
    logic [1:0] data_bit_num_i;
    logic       parity_en_i;
    logic       parity_type_i;
    logic       stop_bit_num_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       parity_err_o;
    logic       stop_bit_err_o;
    logic       busy_o;
    modport master (
        output rx_en_i, tick_i, rx_i, data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i,
        input  data_o, data_valid_o, parity_err_o, stop_bit_err_o, busy_o
    );
    modport slave (
        input  rx_en_i, tick_i, rx_i, data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i,
        output data_o, data_valid_o, parity_err_o, stop_bit_err_o, busy_o
    );
endinterface

// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: oversampled UART receiver with 3-sample majority vote per bit
module uart_rx_oversampler #(
    parameter int SAMPLING_RATE = 16
) (
    input logic                  clk,
    input logic                  reset,
    uart_rx_oversampler_if.slave bus
);
    localparam int CW = $clog2(SAMPLING_RATE);
    localparam logic [CW-1:0] C_M0   = CW'(SAMPLING_RATE / 2 - 1);
    localparam logic [CW-1:0] C_M1   = CW'(SAMPLING_RATE / 2);
    localparam logic [CW-1:0] C_M2   = CW'(SAMPLING_RATE / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(SAMPLING_RATE - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t        r_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [1:0]    r_v;
    logic [1:0]    r_nbits;
    logic          r_par_en, r_par_type, r_stop2, r_stop_idx;
    logic          r_par_err, r_stop_err, r_armed;
    logic [7:0]    r_data;
    logic          r_valid, r_perr_o, r_serr_o;
    logic          w_rx_s, w_vote, w_decide, w_wrap, w_last_bit;
    assign w_rx_s     = r_sync[1];
    assign w_vote     = (r_v[0] & r_v[1]) | (r_v[0] & w_rx_s) | (r_v[1] & w_rx_s);
    assign w_decide   = bus.tick_i && r_cnt == C_M2;
    assign w_wrap     = bus.tick_i && r_cnt == C_LAST;
    assign w_last_bit = r_bit == 3'd4 + {1'b0, r_nbits};
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sync     <= 2'b11;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_v        <= 2'b11;
            r_nbits    <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_armed    <= 1'b1;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_o   <= 1'b0;
            r_serr_o   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], bus.rx_i};
            r_valid <= 1'b0;
            // a held-low line must return high before another start is accepted
            if (w_rx_s) r_armed <= 1'b1;
            if (!bus.rx_en_i) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (bus.tick_i) begin
                r_cnt <= (r_state == IDLE || r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
                if (r_cnt == C_M0) r_v[0] <= w_rx_s;
                if (r_cnt == C_M1) r_v[1] <= w_rx_s;
                case (r_state)
                    IDLE: if (!w_rx_s && r_armed) begin
                        r_state    <= START;
                        r_nbits    <= bus.data_bit_num_i;
                        r_par_en   <= bus.parity_en_i;
                        r_par_type <= bus.parity_type_i;
                        r_stop2    <= bus.stop_bit_num_i;
                        r_shift    <= '0;
                        r_par_err  <= 1'b0;
                        r_stop_err <= 1'b0;
                        r_stop_idx <= 1'b0;
                    end
                    START: if (w_decide && w_vote) r_state <= IDLE;
                        else if (w_wrap) begin
                            r_state <= DATA;
                            r_bit   <= '0;
                        end
                    DATA: begin
                        if (w_decide) r_shift[r_bit] <= w_vote;
                        if (w_wrap && w_last_bit) r_state <= r_par_en ? PARITY : STOP;
                        else if (w_wrap) r_bit <= r_bit + 3'd1;
                    end
                    PARITY: begin
                        if (w_decide && w_vote != (^r_shift ^ r_par_type)) r_par_err <= 1'b1;
                        if (w_wrap) r_state <= STOP;
                    end
                    STOP: begin
                        if (w_decide && r_stop_idx == r_stop2) begin
                            r_data   <= r_shift;
                            r_perr_o <= r_par_err;
                            r_serr_o <= r_stop_err | ~w_vote;
                            r_valid  <= 1'b1;
                            r_state  <= IDLE;
                            r_cnt    <= '0;
                            r_armed  <= w_vote;
                        end else if (w_decide) r_stop_err <= r_stop_err | ~w_vote;
                        if (w_wrap) r_stop_idx <= 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    assign bus.data_o         = r_data;
    assign bus.data_valid_o   = r_valid;
    assign bus.parity_err_o   = r_perr_o;
    assign bus.stop_bit_err_o = r_serr_o;
    assign bus.busy_o         = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb_uart_rx_oversampler: directed frames at 16x oversampling, one tick every 4 clocks
module tb_uart_rx_oversampler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int passed = 0;
    int total = 0;
    logic [9:0] cap_q[$];
    logic [9:0] got;
    uart_rx_oversampler_if bus();
    uart_rx_oversampler #(.SAMPLING_RATE(16)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk)
        if (bus.data_valid_o === 1'b1) cap_q.push_back({bus.stop_bit_err_o, bus.parity_err_o, bus.data_o});

    task automatic do_ticks(input int n);
        repeat (n) begin
            repeat (3) @(posedge clk);
            #1 bus.tick_i = 1'b1;
            @(posedge clk);
            #1 bus.tick_i = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        for (int t = 0; t < 16; t++) begin
            bus.rx_i = (glitch && t == 8) ? ~b : b;
            do_ticks(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input logic par_en, input logic par_bit,
                              input logic stop2_en, input logic stop2_val, input logic glitch);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < n; i++) send_bit(d[i], glitch);
        if (par_en) send_bit(par_bit, 1'b0);
        send_bit(1'b1, 1'b0);
        if (stop2_en) send_bit(stop2_val, 1'b0);
    endtask

    task automatic idle(input int n);
        bus.rx_i = 1'b1;
        do_ticks(n);
    endtask

    task automatic cfg(input logic [1:0] nb, input logic pe, input logic pt, input logic s2);
        bus.data_bit_num_i = nb;
        bus.parity_en_i    = pe;
        bus.parity_type_i  = pt;
        bus.stop_bit_num_i = s2;
        cap_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.data_o !== 8'h00) $display("FAIL reset_data got=%h exp=00", bus.data_o); else passed++;
        total++; if ({bus.data_valid_o, bus.parity_err_o, bus.stop_bit_err_o, bus.busy_o} !== 4'b0000)
            $display("FAIL reset_flags got=%b exp=0000", {bus.data_valid_o, bus.parity_err_o, bus.stop_bit_err_o, bus.busy_o});
        else passed++;
        reset = 1'b0;
        idle(4);
        total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", bus.busy_o); else passed++;
    endtask

    task automatic test_8n1();
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        total++; if (cap_q.size() !== 1) $display("FAIL 8n1_count got=%0d exp=1", cap_q.size()); else passed++;
        got = cap_q.size() > 0 ? cap_q.pop_front() : 10'bx;
        total++; if (got !== 10'h0A5) $display("FAIL 8n1_frame got=%h exp=0a5", got); else passed++;
        total++; if (bus.data_o !== 8'hA5 || bus.busy_o !== 1'b0)
            $display("FAIL 8n1_hold got=%h/%b exp=a5/0", bus.data_o, bus.busy_o);
        else passed++;
    endtask

    task automatic test_parity();
        cfg(2'b10, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        total++; if (cap_q.size() !== 1) $display("FAIL parity_count got=%0d exp=1", cap_q.size()); else passed++;
        got = cap_q.size() > 0 ? cap_q.pop_front() : 10'bx;
        total++; if (got !== 10'h155) $display("FAIL parity_frame got=%h exp=155", got); else passed++;
        cfg(2'b10, 1'b1, 1'b1, 1'b0);
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        got = cap_q.size() > 0 ? cap_q.pop_front() : 10'bx;
        total++; if (got !== 10'h055) $display("FAIL parity_odd_ok got=%h exp=055", got); else passed++;
    endtask

    task automatic test_stop2();
        cfg(2'b11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        total++; if (cap_q.size() !== 1) $display("FAIL stop2_count got=%0d exp=1", cap_q.size()); else passed++;
        got = cap_q.size() > 0 ? cap_q.pop_front() : 10'bx;
        total++; if (got !== 10'h23C) $display("FAIL stop2_frame got=%h exp=23c", got); else passed++;
    endtask

    task automatic test_false_start();
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        bus.rx_i = 1'b0;
        do_ticks(4);
        total++; if (bus.busy_o !== 1'b1) $display("FAIL false_start_busy got=%b exp=1", bus.busy_o); else passed++;
        idle(12);
        total++; if (bus.busy_o !== 1'b0) $display("FAIL false_start_idle got=%b exp=0", bus.busy_o); else passed++;
        total++; if (cap_q.size() !== 0) $display("FAIL false_start_valid got=%0d exp=0", cap_q.size()); else passed++;
    endtask

    task automatic test_break();
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        bus.rx_i = 1'b0;
        do_ticks(10 * 16 + 20);
        total++; if (cap_q.size() !== 1) $display("FAIL break_count got=%0d exp=1", cap_q.size()); else passed++;
        got = cap_q.size() > 0 ? cap_q.pop_front() : 10'bx;
        total++; if (got !== 10'h200) $display("FAIL break_frame got=%h exp=200", got); else passed++;
        total++; if (bus.busy_o !== 1'b0) $display("FAIL break_rearm got=%b exp=0", bus.busy_o); else passed++;
        idle(4);
    endtask

    task automatic test_glitch();
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);
        got = cap_q.size() > 0 ? cap_q.pop_front() : 10'bx;
        total++; if (got !== 10'h0F0) $display("FAIL glitch_frame got=%h exp=0f0", got); else passed++;
    endtask

    task automatic test_back_to_back();
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        bus.rx_i = 1'b1;
        do_ticks(5);
        #1 bus.rx_en_i = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.busy_o !== 1'b0) $display("FAIL disable_busy got=%b exp=0", bus.busy_o); else passed++;
        do_ticks(3);
        bus.rx_en_i = 1'b1;
        idle(4);
        total++; if (cap_q.size() !== 0 || bus.data_o !== 8'hF0)
            $display("FAIL disable_hold got=%0d/%h exp=0/f0", cap_q.size(), bus.data_o);
        else passed++;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        bus.rx_i = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        total++; if ({bus.data_o, bus.data_valid_o, bus.parity_err_o, bus.stop_bit_err_o, bus.busy_o} !== 12'h000)
            $display("FAIL midreset got=%h exp=000", {bus.data_o, bus.data_valid_o, bus.parity_err_o, bus.stop_bit_err_o, bus.busy_o});
        else passed++;
        idle(4);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        total++; if (cap_q.size() !== 2) $display("FAIL b2b_count got=%0d exp=2", cap_q.size()); else passed++;
        got = cap_q.size() > 0 ? cap_q.pop_front() : 10'bx;
        total++; if (got !== 10'h011) $display("FAIL b2b_first got=%h exp=011", got); else passed++;
        got = cap_q.size() > 0 ? cap_q.pop_front() : 10'bx;
        total++; if (got !== 10'h022) $display("FAIL b2b_second got=%h exp=022", got); else passed++;
    endtask

    initial begin
        bus.rx_en_i = 1'b1;
        bus.tick_i = 1'b0;
        bus.rx_i = 1'b1;
        bus.data_bit_num_i = 2'b11;
        bus.parity_en_i = 1'b0;
        bus.parity_type_i = 1'b0;
        bus.stop_bit_num_i = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_false_start();
        test_break();
        test_glitch();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
